// File: rtl/axi_dma_rd.sv
// rtl/axi_dma_rd.sv - AXI4 read DMA engine: fixed-length INCR bursts into a FWFT FIFO,
// replayed as an AXI-Stream with per-pass tlast and optional looping.
module axi_dma_rd #(
  parameter int DATA_W          = 128,
  parameter int ADDR_W          = 32,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 128
) (
  input  logic              ps_clk,
  input  logic              ps_rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [31:0]       play_size,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              rd_err,
  output logic [ADDR_W-1:0] current_addr,
  output logic [15:0]       burst_cnt
);
  localparam int BB    = BURST_LEN * DATA_W / 8;
  localparam int BB_LG = $clog2(BB);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int RES_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
  localparam logic [RES_W-1:0] RES_LIMIT = RES_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [RES_W-1:0] RES_BL    = RES_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, RUN, ABORT, DONE} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] base, cur_addr;
  logic [31:0]       nb, bursts_left, last_idx, out_cnt, nb_in;
  logic [OUT_W-1:0]  outstanding;
  logic [RES_W-1:0]  reserved;
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              ar_hold, start_ok, ar_ok, ar_hs, r_hs, rlast_hs, ax_hs;
  logic              fifo_wr, fifo_empty, finish;
  logic [ADDR_W-1:0] base_in;

  assign nb_in    = play_size >> BB_LG;
  assign base_in  = {start_address[ADDR_W-1:BB_LG], {BB_LG{1'b0}}};
  assign start_ok = start && !stop && (state == IDLE || state == DONE);
  // Issue only when the whole burst already has a FIFO slot reserved.
  assign ar_ok    = (state == RUN) && (bursts_left != 32'd0) &&
                    (outstanding < MAX_OUT_C) && (reserved <= RES_LIMIT);

  assign m_axi_arvalid = ar_hold || ar_ok;
  assign m_axi_araddr  = cur_addr;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
  assign m_axi_arburst = 2'b01;
  assign busy          = (state == RUN) || (state == ABORT);
  assign done          = (state == DONE);
  assign m_axi_rready  = busy;
  assign current_addr  = cur_addr;

  assign ar_hs      = m_axi_arvalid && m_axi_arready;
  assign r_hs       = m_axi_rvalid && m_axi_rready;
  assign rlast_hs   = r_hs && m_axi_rlast;
  assign fifo_wr    = (state == RUN) && !stop && r_hs;
  assign fifo_empty = (wr_ptr == rd_ptr);

  assign m_axis_tvalid = (state == RUN) && !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr[PTR_W-1:0]] : '0;
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt == last_idx);
  assign ax_hs         = m_axis_tvalid && m_axis_tready;
  // Last beat anywhere in the system: nothing left to request, in flight or buffered behind it.
  assign finish = ax_hs && m_axis_tlast && (bursts_left == 32'd0) &&
                  (outstanding == '0) && (reserved == RES_W'(1)) && !m_axi_arvalid;

  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nx = (nb_in == 32'd0) ? DONE : RUN;
      RUN:        if (stop) state_nx = ABORT;
                  else if (finish) state_nx = DONE;
      ABORT:      if (outstanding == '0 && !m_axi_arvalid) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ps_clk) begin
    if (fifo_wr) mem[wr_ptr[PTR_W-1:0]] <= m_axi_rdata;
  end

  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) begin
      base <= '0; cur_addr <= '0; nb <= '0; bursts_left <= '0; last_idx <= '0;
      out_cnt <= '0; outstanding <= '0; reserved <= '0; wr_ptr <= '0; rd_ptr <= '0;
      ar_hold <= 1'b0; rd_err <= 1'b0; burst_cnt <= '0;
    end else if (start_ok) begin
      base <= base_in; cur_addr <= base_in; nb <= nb_in; bursts_left <= nb_in;
      last_idx <= 32'(nb_in * BURST_LEN) - 32'd1;
      out_cnt <= '0; outstanding <= '0; reserved <= '0; wr_ptr <= '0; rd_ptr <= '0;
      ar_hold <= 1'b0; rd_err <= 1'b0; burst_cnt <= '0;
    end else begin
      ar_hold <= m_axi_arvalid && !m_axi_arready;
      if (ar_hs) begin
        burst_cnt <= burst_cnt + 16'd1;
        // Looping reloads on the final handshake so the next pass follows without a gap.
        if (bursts_left == 32'd1 && loop_en && state == RUN) begin
          cur_addr    <= base;
          bursts_left <= nb;
        end else begin
          cur_addr    <= cur_addr + ADDR_W'(BB);
          bursts_left <= bursts_left - 32'd1;
        end
      end
      case ({ar_hs, rlast_hs})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (r_hs && m_axi_rresp != 2'b00) rd_err <= 1'b1;
      if (state == RUN) begin
        if (stop) begin
          wr_ptr <= '0; rd_ptr <= '0; reserved <= '0; out_cnt <= '0;
        end else begin
          if (fifo_wr) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
          if (ax_hs) begin
            rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
            out_cnt <= m_axis_tlast ? 32'd0 : out_cnt + 32'd1;
          end
          reserved <= reserved + (ar_hs ? RES_BL : '0) - RES_W'(ax_hs);
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_dma_rd.sv
// tb/tb_axi_dma_rd.sv - bench for axi_dma_rd: randomized AXI slave and stream sink
// checked against an address/beat-index model of each playback pass.
module tb_axi_dma_rd;
  localparam int DW = 128;
  localparam int BB = 256;

  logic          ps_clk = 1'b0, ps_rst = 1'b1;
  logic          start = 0, stop = 0, loop_en = 0;
  logic [31:0]   start_address = 0, play_size = 0;
  logic [31:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready = 0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = 0;
  logic          m_axi_rlast = 0, m_axi_rvalid = 0, m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;
  logic          busy, done, rd_err;
  logic [31:0]   current_addr;
  logic [15:0]   burst_cnt;

  axi_dma_rd dut (
    .ps_clk(ps_clk), .ps_rst(ps_rst), .start(start), .stop(stop), .loop_en(loop_en),
    .start_address(start_address), .play_size(play_size),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .rd_err(rd_err),
    .current_addr(current_addr), .burst_cnt(burst_cnt)
  );

  always #5 ps_clk = ~ps_clk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bus modes: 0 always ready/valid, 1 random, 2 withheld.
  int ar_mode = 0, r_mode = 0, t_mode = 0, err_beat = -1;
  logic [31:0] m_base = 0;
  int m_nb = 0, ar_n = 0, ax_n = 0, rb_n = 0, outst_tb = 0, r_beat = 0;
  logic [31:0] rq[$];
  bit r_pend = 0;

  // DUT outputs depend only on its registers, so values seen here plus the inputs
  // driven now are exactly the handshakes taken at the next rising edge.
  always @(negedge ps_clk) begin
    if (ps_rst) begin
      m_axi_arready = 0; m_axi_rvalid = 0; m_axis_tready = 0;
      r_pend = 0; r_beat = 0; outst_tb = 0; rq.delete();
    end else begin
      if (!r_pend) begin
        if (rq.size() > 0 && (r_mode == 0 || (r_mode == 1 && $urandom_range(0, 1) == 1))) begin
          m_axi_rvalid = 1;
          m_axi_rdata  = {4{rq[0] + 32'(r_beat * 16)}};
          m_axi_rlast  = (r_beat == 15);
          m_axi_rresp  = (rb_n == err_beat) ? 2'b10 : 2'b00;
          r_pend = 1;
        end else m_axi_rvalid = 0;
      end
      if (r_pend && m_axi_rready) begin
        r_pend = 0; rb_n++; r_beat++;
        if (m_axi_rlast) begin r_beat = 0; void'(rq.pop_front()); outst_tb--; end
      end
      m_axi_arready = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        if (m_nb == 0) chk("ar_unexpected", 1, 0);
        else chk("araddr", m_axi_araddr, m_base + 32'((ar_n % m_nb) * BB));
        ar_n++; outst_tb++;
        rq.push_back(m_axi_araddr);
        chk("outstanding_max", outst_tb <= 4, 1);
      end
      m_axis_tready = (t_mode == 0) ? 1'b1 : (t_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (m_nb == 0) chk("beat_unexpected", 1, 0);
        else begin
          chk("tdata", m_axis_tdata, {4{m_base + 32'((ax_n % (m_nb * 16)) * 16)}});
          chk("tlast", m_axis_tlast, (ax_n % (m_nb * 16)) == m_nb * 16 - 1);
        end
        ax_n++;
      end
    end
  end

  task automatic go(input logic [31:0] base, input logic [31:0] size, input logic lp);
    @(negedge ps_clk); #1;
    m_base = base & 32'hFFFF_FF00; m_nb = int'(size >> 8);
    ar_n = 0; ax_n = 0; rb_n = 0;
    start_address = base; play_size = size; loop_en = lp; start = 1;
    @(negedge ps_clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge ps_clk); #1; n++; end
    chk(name, done, 1);
  endtask

  typedef struct {
    logic [31:0] base; logic [31:0] size;
    int t_m; int ar_m; int r_m; int err;
    int exp_ars; int exp_beats; logic exp_err;
  } vec_t;
  vec_t tbl[4];

  int snap, n;
  initial begin
    tbl[0] = '{32'h1000_0000, 32'h400,  0, 0, 0, -1, 4,  64,  1'b0};
    tbl[1] = '{32'h2000_0080, 32'h4FF,  1, 1, 1, -1, 4,  64,  1'b0};
    tbl[2] = '{32'h1000_0000, 32'h400,  0, 0, 0,  5, 4,  64,  1'b1};
    tbl[3] = '{32'h3000_0000, 32'h1000, 1, 1, 1, -1, 16, 256, 1'b0};

    repeat (3) @(negedge ps_clk); #1;
    chk("reset_ctl", {m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, busy, done, rd_err}, 0);
    chk("reset_addr", {m_axi_araddr, current_addr, burst_cnt}, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    chk("ar_consts", {m_axi_arlen, m_axi_arsize, m_axi_arburst}, {8'd15, 3'd4, 2'd1});
    ps_rst = 0;

    foreach (tbl[i]) begin
      t_mode = tbl[i].t_m; ar_mode = tbl[i].ar_m; r_mode = tbl[i].r_m; err_beat = tbl[i].err;
      go(tbl[i].base, tbl[i].size, 1'b0);
      chk("start_busy", busy, 1);
      chk("start_rd_err_clr", rd_err, 0);
      wait_done("tbl_done", 6000);
      chk("tbl_ars", ar_n, tbl[i].exp_ars);
      chk("tbl_beats", ax_n, tbl[i].exp_beats);
      chk("tbl_busy", busy, 0);
      chk("tbl_burst_cnt", burst_cnt, 16'(tbl[i].exp_ars));
      chk("tbl_rd_err", rd_err, tbl[i].exp_err);
      chk("tbl_cur_addr", current_addr, m_base + 32'(tbl[i].exp_ars * BB));
    end
    err_beat = -1;

    // Credit limit: stalled sink lets only FIFO_DEPTH/BURST_LEN bursts be requested.
    t_mode = 2; ar_mode = 0; r_mode = 0;
    go(32'h1000_0000, 32'h1000, 1'b0);
    repeat (500) @(negedge ps_clk); #1;
    chk("credit_ars", ar_n, 8);
    chk("credit_rbeats", rb_n, 128);
    chk("credit_tvalid", m_axis_tvalid, 1);
    t_mode = 0;
    wait_done("credit_done", 3000);
    chk("credit_beats", ax_n, 256);

    // Outstanding limit with read data withheld.
    r_mode = 2;
    go(32'h0, 32'h2000, 1'b0);
    repeat (50) @(negedge ps_clk); #1;
    chk("outst_ars", ar_n, 4);
    r_mode = 0;
    wait_done("outst_done", 3000);
    chk("outst_total", ar_n, 32);

    // Loop playback, then drop loop_en mid-pass.
    t_mode = 1; ar_mode = 1; r_mode = 1;
    go(32'h0, 32'h200, 1'b1);
    n = 0;
    while (ax_n < 106 && n < 3000) begin @(negedge ps_clk); #1; n++; end
    chk("loop_progress", ax_n >= 106, 1);
    chk("loop_busy", busy, 1);
    loop_en = 0;
    wait_done("loop_done", 3000);
    chk("loop_whole_pass", ax_n % 32, 0);
    chk("loop_ar_beats", ar_n * 16, ax_n);

    // Abort with bursts in flight.
    t_mode = 2; ar_mode = 0; r_mode = 0;
    go(32'h4000_0000, 32'h2000, 1'b0);
    n = 0;
    while (rb_n < 32 && n < 500) begin @(negedge ps_clk); #1; n++; end
    r_mode = 2;
    repeat (20) @(negedge ps_clk); #1;
    chk("abort_pre_outst", outst_tb, 4);
    snap = ar_n;
    stop = 1;
    @(negedge ps_clk); #1;
    stop = 0;
    chk("abort_tvalid", m_axis_tvalid, 0);
    chk("abort_rready", m_axi_rready, 1);
    r_mode = 0; t_mode = 0;
    n = 0;
    while (outst_tb != 0 && n < 500) begin @(negedge ps_clk); #1; n++; end
    chk("abort_drained", outst_tb, 0);
    chk("abort_busy_hold", busy, 1);
    repeat (2) @(negedge ps_clk); #1;
    chk("abort_idle", {busy, done, m_axis_tvalid}, 0);
    chk("abort_no_new_ar", ar_n, snap);
    chk("abort_all_beats", rb_n, snap * 16);

    // Asynchronous reset in the middle of a run.
    go(32'h5000_0000, 32'h1000, 1'b0);
    repeat (30) @(negedge ps_clk); #1;
    ps_rst = 1;
    #1;
    chk("rst_ctl", {m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, busy, done, rd_err}, 0);
    chk("rst_addr", {m_axi_araddr, current_addr, burst_cnt}, 0);
    @(negedge ps_clk); #1;
    ps_rst = 0;

    // Zero-length pass.
    go(32'h6000_0000, 32'h0, 1'b0);
    chk("zero_done", {done, busy}, 2'b10);
    repeat (20) @(negedge ps_clk); #1;
    chk("zero_no_ar", ar_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
